// File: rtl/chal_sequencer.sv
// chal_sequencer: captures the challenged-repetition list Lc and the
// hidden-party list Lp, validates them, builds the challenged-repetition
// mask and streams one response record per repetition (0..7) over a
// valid/ready interface.
module chal_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs_start,
    input  logic [19:0] Lc,
    input  logic [19:0] Lp,
    output logic        rec_valid,
    input  logic        rec_ready,
    output logic [2:0]  rec_rep,
    output logic        rec_chal,
    output logic [3:0]  rec_hidden,
    output logic [15:0] rec_open_mask,
    output logic [7:0]  chal_mask,
    output logic        cs_done,
    output logic        cs_err
);

    typedef enum logic [1:0] {IDLE, CHECK, EMIT, DONE} state_t;

    state_t      state;
    logic [19:0] lc_q;
    logic [19:0] lp_q;
    logic [2:0]  rep;

    // Next-record source: rep 0 with the freshly built mask while checking,
    // rep+1 with the registered mask while emitting.
    logic [7:0]  nxt_mask;
    logic [2:0]  src_rep;
    logic [7:0]  src_mask;
    logic        nxt_chal;
    logic [3:0]  nxt_hidden;
    logic [15:0] nxt_open;

    // Entry k of a packed list; entry 0 sits in the top five bits.
    function automatic logic [4:0] entry(input logic [19:0] v, input int k);
        return v[(3 - k) * 5 +: 5];
    endfunction

    // Rejects out-of-range repetitions, out-of-range parties and repeated
    // repetitions. Full 5-bit compares so upper bits count as differences.
    function automatic logic lists_bad(input logic [19:0] lc, input logic [19:0] lp);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (entry(lc, k) >= 5'd8)  bad = 1'b1;
            if (entry(lp, k) >= 5'd16) bad = 1'b1;
            for (int j = k + 1; j < 4; j++) begin
                if (entry(lc, k) == entry(lc, j)) bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // One bit per challenged repetition; only meaningful for accepted lists.
    function automatic logic [7:0] build_mask(input logic [19:0] lc);
        logic [7:0] m;
        m = 8'h00;
        for (int k = 0; k < 4; k++) begin
            m = m | (8'h01 << entry(lc, k)[2:0]);
        end
        return m;
    endfunction

    // Hidden party of the list entry that challenges repetition r.
    function automatic logic [3:0] hidden_for(input logic [2:0] r,
                                              input logic [19:0] lc,
                                              input logic [19:0] lp);
        logic [3:0] h;
        h = 4'd0;
        for (int k = 0; k < 4; k++) begin
            if (entry(lc, k)[2:0] == r) h = entry(lp, k)[3:0];
        end
        return h;
    endfunction

    // Computes the record to be loaded at the next state transition.
    always_comb begin
        nxt_mask   = build_mask(lc_q);
        src_rep    = 3'd0;
        src_mask   = nxt_mask;
        if (state == EMIT) begin
            src_rep  = rep + 3'd1;
            src_mask = chal_mask;
        end
        nxt_chal   = src_mask[src_rep];
        nxt_hidden = 4'd0;
        nxt_open   = 16'h0000;
        if (nxt_chal) begin
            nxt_hidden = hidden_for(src_rep, lc_q, lp_q);
            nxt_open   = ~(16'h0001 << nxt_hidden);
        end
    end

    // Sequencer FSM with registered record and status outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            lc_q          <= 20'd0;
            lp_q          <= 20'd0;
            rep           <= 3'd0;
            rec_valid     <= 1'b0;
            rec_rep       <= 3'd0;
            rec_chal      <= 1'b0;
            rec_hidden    <= 4'd0;
            rec_open_mask <= 16'h0000;
            chal_mask     <= 8'h00;
            cs_done       <= 1'b0;
            cs_err        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_start && !cs_done) begin
                        lc_q      <= Lc;
                        lp_q      <= Lp;
                        cs_err    <= 1'b0;
                        chal_mask <= 8'h00;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (!cs_start) begin
                        state <= IDLE;
                    end else if (lists_bad(lc_q, lp_q)) begin
                        cs_err    <= 1'b1;
                        chal_mask <= 8'h00;
                        cs_done   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        chal_mask     <= nxt_mask;
                        rep           <= 3'd0;
                        rec_valid     <= 1'b1;
                        rec_rep       <= 3'd0;
                        rec_chal      <= nxt_chal;
                        rec_hidden    <= nxt_hidden;
                        rec_open_mask <= nxt_open;
                        state         <= EMIT;
                    end
                end
                EMIT: begin
                    if (!cs_start || (rec_ready && rep == 3'd7)) begin
                        // Abort (or last transfer): drop the record stream.
                        rec_valid     <= 1'b0;
                        rec_rep       <= 3'd0;
                        rec_chal      <= 1'b0;
                        rec_hidden    <= 4'd0;
                        rec_open_mask <= 16'h0000;
                        if (cs_start) begin
                            cs_done <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state   <= IDLE;
                        end
                    end else if (rec_ready) begin
                        rep           <= src_rep;
                        rec_rep       <= src_rep;
                        rec_chal      <= nxt_chal;
                        rec_hidden    <= nxt_hidden;
                        rec_open_mask <= nxt_open;
                    end
                end
                DONE: begin
                    if (!cs_start) begin
                        cs_done <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_chal_sequencer.sv
// Scoreboard bench for chal_sequencer: expected records are queued when a
// request is issued and compared as the DUT transfers them.
module tb_chal_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cs_start = 1'b0;
    logic [19:0] Lc = 20'd0;
    logic [19:0] Lp = 20'd0;
    logic        rec_valid;
    logic        rec_ready = 1'b0;
    logic [2:0]  rec_rep;
    logic        rec_chal;
    logic [3:0]  rec_hidden;
    logic [15:0] rec_open_mask;
    logic [7:0]  chal_mask;
    logic        cs_done;
    logic        cs_err;

    int checks = 0;
    int errors = 0;
    int xfer_cnt = 0;
    int rdy_mode = 0;       // 0: always ready, 1: random, 2: never ready
    logic [23:0] sb[$];
    logic        prev_stall = 1'b0;
    logic [23:0] prev_rec = 24'd0;

    chal_sequencer dut (
        .clk(clk), .reset(reset), .cs_start(cs_start), .Lc(Lc), .Lp(Lp),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_rep(rec_rep),
        .rec_chal(rec_chal), .rec_hidden(rec_hidden),
        .rec_open_mask(rec_open_mask), .chal_mask(chal_mask),
        .cs_done(cs_done), .cs_err(cs_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [4:0] fld(input logic [19:0] v, input int k);
        logic [19:0] t;
        t = v >> ((3 - k) * 5);
        return t[4:0];
    endfunction

    function automatic logic model_bad(input logic [19:0] lc, input logic [19:0] lp);
        logic b;
        b = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (fld(lc, k) > 5'd7 || fld(lp, k) > 5'd15) b = 1'b1;
            for (int j = 0; j < k; j++) if (fld(lc, j) == fld(lc, k)) b = 1'b1;
        end
        return b;
    endfunction

    function automatic logic [7:0] model_mask(input logic [19:0] lc);
        logic [7:0] m;
        m = 8'h00;
        for (int k = 0; k < 4; k++) m[fld(lc, k)] = 1'b1;
        return m;
    endfunction

    // Packed record {rep, chal, hidden, open_mask}.
    function automatic logic [23:0] model_rec(input logic [19:0] lc, input logic [19:0] lp, input int r);
        logic        c;
        logic [3:0]  h;
        logic [15:0] o;
        logic [4:0]  p;
        c = 1'b0; h = 4'd0; o = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            if (int'(fld(lc, k)) == r) begin
                c = 1'b1;
                p = fld(lp, k);
                h = p[3:0];
            end
        end
        if (c) begin
            o = 16'hFFFF;
            o[h] = 1'b0;
        end
        return {r[2:0], c, h, o};
    endfunction

    // Ready driver, updated just after each active edge.
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0)      rec_ready = 1'b1;
        else if (rdy_mode == 1) rec_ready = 1'($urandom_range(0, 1));
        else                    rec_ready = 1'b0;
    end

    // Record monitor: checks stall stability and scores every transfer.
    always @(negedge clk) begin
        logic [23:0] cur;
        cur = {rec_rep, rec_chal, rec_hidden, rec_open_mask};
        if (prev_stall && rec_valid) chk("stall_hold", cur, prev_rec);
        if (rec_valid && rec_ready) begin
            xfer_cnt++;
            if (sb.size() == 0) chk("sb_underflow", cur, 24'hFFFFFF);
            else chk("rec", cur, sb.pop_front());
        end
        prev_stall = rec_valid && !rec_ready;
        prev_rec   = cur;
    end

    task automatic run_seq(input logic [19:0] lc, input logic [19:0] lp, input int mode);
        logic bad;
        int   cyc;
        bad = model_bad(lc, lp);
        sb.delete();
        if (!bad) for (int r = 0; r < 8; r++) sb.push_back(model_rec(lc, lp, r));
        @(posedge clk); #1;
        rdy_mode = mode;
        xfer_cnt = 0;
        Lc = lc; Lp = lp; cs_start = 1'b1;
        cyc = 0;
        @(negedge clk);
        while (!cs_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 400) chk("done_timeout", 0, 1);
        if (mode == 0) chk("done_latency", cyc, bad ? 2 : 10);
        chk("cs_err", cs_err, bad);
        chk("chal_mask", chal_mask, bad ? 8'h00 : model_mask(lc));
        chk("xfer_count", xfer_cnt, bad ? 0 : 8);
        chk("sb_left", sb.size(), 0);
        // Holding the request keeps done asserted without a re-run.
        repeat (3) @(negedge clk);
        chk("done_hold", cs_done, 1);
        chk("no_rerun", {rec_valid, xfer_cnt[7:0]}, {1'b0, (bad ? 8'd0 : 8'd8)});
        @(posedge clk); #1;
        cs_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("done_clear", cs_done, 0);
        chk("err_hold", cs_err, bad);
        chk("mask_hold", chal_mask, bad ? 8'h00 : model_mask(lc));
    endtask

    initial begin
        #23;
        chk("rst_outs", {rec_valid, cs_done, cs_err, chal_mask, rec_open_mask, rec_hidden, rec_rep, rec_chal}, 0);
        @(negedge clk);
        reset = 1'b1;

        // Nominal
        run_seq(20'h180C1, 20'h2BC09, 0);
        chk("nominal_mask", chal_mask, 8'h4B);
        // Backpressure, then a second valid pattern under backpressure
        run_seq(20'h180C1, 20'h2BC09, 1);
        run_seq({5'd7, 5'd4, 5'd2, 5'd5}, {5'd1, 5'd2, 5'd3, 5'd4}, 1);
        // Duplicate and range errors
        run_seq({5'd2, 5'd2, 5'd5, 5'd7}, 20'd0, 0);
        run_seq({5'd8, 5'd0, 5'd1, 5'd2}, 20'd0, 0);
        run_seq(20'h180C1, {5'd5, 5'd15, 5'd0, 5'd16}, 0);

        // Abort during a rep 4 stall
        sb.delete();
        for (int r = 0; r < 8; r++) sb.push_back(model_rec(20'h180C1, 20'h2BC09, r));
        @(posedge clk); #1;
        rdy_mode = 0; xfer_cnt = 0;
        Lc = 20'h180C1; Lp = 20'h2BC09; cs_start = 1'b1;
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!(rec_valid && rec_rep == 3'd3) && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) chk("abort_reach_rep3", 0, 1);
        end
        rdy_mode = 2;
        @(negedge clk);
        chk("abort_stall_rep", {rec_valid, rec_ready, rec_rep}, {1'b1, 1'b0, 3'd4});
        @(posedge clk); #1;
        cs_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_valid_drop", {rec_valid, cs_done}, 2'b00);
        chk("abort_xfers", xfer_cnt, 4);
        chk("abort_inflight", sb.size(), 4);
        repeat (4) @(negedge clk);
        chk("abort_no_done", {rec_valid, cs_done}, 2'b00);
        // Restart completes normally
        run_seq(20'h180C1, 20'h2BC09, 0);

        // Reset mid-EMIT at rep 3
        sb.delete();
        for (int r = 0; r < 8; r++) sb.push_back(model_rec(20'h180C1, 20'h2BC09, r));
        @(posedge clk); #1;
        rdy_mode = 2; xfer_cnt = 0;
        cs_start = 1'b1;
        @(negedge clk);
        rdy_mode = 0;
        begin
            int n;
            n = 0;
            while (!(rec_valid && rec_rep == 3'd3) && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) chk("reset_reach_rep3", 0, 1);
        end
        #1;
        reset = 1'b0;
        #1;
        chk("reset_outs", {rec_valid, cs_done, cs_err, chal_mask, rec_open_mask, rec_hidden, rec_rep, rec_chal}, 0);
        cs_start = 1'b0;
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("reset_idle", {rec_valid, cs_done, cs_err, chal_mask}, 0);
        chk("reset_no_xfer", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
